// File: rtl/lscnt_timer_ctrl.sv
// lscnt_timer_ctrl: sequencing controller for an LSCNTEL down-counter chain.
// Drives the chain's load strobes, load data and carry-in. Holds the host reload
// value and control bits, detects terminal count and raises a held interrupt.
// Optional feature macro: LSCNT_CTRL_PRESCALE_EN (tick every P+1 RUN cycles).
module lscnt_timer_ctrl #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned PRE_W = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             WR_RELOAD,
  input  logic [WIDTH-1:0] RELOAD_D,
  input  logic             WR_CTRL,
  input  logic [2:0]       CTRL_D,
  input  logic [PRE_W-1:0] PRESCALE_D,
  input  logic             STOP,
  input  logic             IRQ_ACK,
  input  logic             CHAIN_CO,
  input  logic [WIDTH-1:0] CNT_Q,
  output logic             LD,
  output logic             LDL,
  output logic [WIDTH-1:0] CNT_D,
  output logic             CI,
  output logic             IRQ,
  output logic             BUSY
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             auto_q, auto_d;
  logic             irq_en_q, irq_en_d;
  logic             irq_q, irq_d;

  logic start_cmd;
  logic in_run;
  logic tick;
  logic zero_q;
  logic decr;
  logic expiry;

  assign start_cmd = WR_CTRL & CTRL_D[0];
  assign in_run    = (state_q == ST_RUN);
  assign zero_q    = (CNT_Q == '0);

`ifdef LSCNT_CTRL_PRESCALE_EN
  logic [PRE_W-1:0] presc_q, presc_d;
  logic [PRE_W-1:0] pcnt_q, pcnt_d;

  // Prescale divisor register and tick phase counter (restarted by LOAD only).
  always_comb begin
    presc_d = WR_CTRL ? PRESCALE_D : presc_q;
    pcnt_d  = pcnt_q;
    if (state_q == ST_LOAD) begin
      pcnt_d = '0;
    end else if (in_run) begin
      pcnt_d = (pcnt_q >= presc_q) ? '0 : pcnt_q + 1'b1;
    end
  end

  // Prescaler state registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      presc_q <= '0;
      pcnt_q  <= '0;
    end else begin
      presc_q <= presc_d;
      pcnt_q  <= pcnt_d;
    end
  end

  assign tick = in_run & (pcnt_q == '0);
`else
  logic [PRE_W-1:0] unused_prescale;
  assign unused_prescale = PRESCALE_D;
  assign tick = in_run;
`endif

  // A STOP cycle holds the chain, but terminal count is only visible on CO
  // while CI is low; so during STOP, CI is dropped only when the chain reads
  // zero, which makes CO report the expiry without a CI->CO->CI loop.
  assign decr   = tick & (start_cmd | ~STOP | zero_q);
  assign expiry = tick & ~CHAIN_CO;

  // Chain drive: load strobes, load data and carry-in.
  always_comb begin
    LD    = 1'b0;
    CNT_D = '0;
    CI    = ~decr;
    if (state_q == ST_LOAD) begin
      LD    = 1'b1;
      CNT_D = reload_q;
    end else if (expiry) begin
      LD    = 1'b1;
      CNT_D = auto_q ? reload_q : '0;
    end
  end

  assign LDL  = ~LD;
  assign IRQ  = irq_q;
  assign BUSY = (state_q == ST_LOAD) | in_run;

  // Next-state, host register writes and interrupt.
  always_comb begin
    state_d  = state_q;
    reload_d = WR_RELOAD ? RELOAD_D : reload_q;
    auto_d   = WR_CTRL ? CTRL_D[1] : auto_q;
    irq_en_d = WR_CTRL ? CTRL_D[2] : irq_en_q;
    irq_d    = irq_q;

    if (IRQ_ACK) irq_d = 1'b0;
    if (expiry && irq_en_q) irq_d = 1'b1;

    unique case (state_q)
      ST_IDLE: if (start_cmd) state_d = ST_LOAD;
      ST_LOAD: state_d = start_cmd ? ST_LOAD : ST_RUN;
      ST_RUN: begin
        if (start_cmd) begin
          state_d = ST_LOAD;
        end else if (expiry) begin
          state_d = (STOP || !auto_q) ? ST_IDLE : ST_RUN;
        end else if (STOP) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and register update with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      reload_q <= '0;
      auto_q   <= 1'b0;
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      reload_q <= reload_d;
      auto_q   <= auto_d;
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end

endmodule

// File: tb/tb_lscnt_timer_ctrl.sv
// Self-checking bench for lscnt_timer_ctrl: a counter-chain environment, a
// cycle-level behavioural reference, and directed scenarios with literal checks.
module tb_lscnt_timer_ctrl;
  localparam int W = 16;
  localparam int P = 8;

  logic         clk = 1'b0;
  logic         RESET = 1'b1;
  logic         WR_RELOAD = 1'b0;
  logic [W-1:0] RELOAD_D = '0;
  logic         WR_CTRL = 1'b0;
  logic [2:0]   CTRL_D = '0;
  logic [P-1:0] PRESCALE_D = '0;
  logic         STOP = 1'b0;
  logic         IRQ_ACK = 1'b0;
  logic         CHAIN_CO;
  logic [W-1:0] CNT_Q;
  logic         LD, LDL, CI, IRQ, BUSY;
  logic [W-1:0] CNT_D;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  lscnt_timer_ctrl #(.WIDTH(W), .PRE_W(P)) dut (
    .CLK(clk), .RESET(RESET), .WR_RELOAD(WR_RELOAD), .RELOAD_D(RELOAD_D),
    .WR_CTRL(WR_CTRL), .CTRL_D(CTRL_D), .PRESCALE_D(PRESCALE_D), .STOP(STOP),
    .IRQ_ACK(IRQ_ACK), .CHAIN_CO(CHAIN_CO), .CNT_Q(CNT_Q), .LD(LD), .LDL(LDL),
    .CNT_D(CNT_D), .CI(CI), .IRQ(IRQ), .BUSY(BUSY)
  );

  always #5 clk = ~clk;

  // Counter chain environment: load beats carry-in; CO low at zero with CI low.
  logic [W-1:0] chain_q = '0;
  assign CNT_Q    = chain_q;
  assign CHAIN_CO = ~((chain_q == '0) & ~CI);
  always @(posedge clk) begin
    if (RESET)    chain_q <= '0;
    else if (LD)  chain_q <= CNT_D;
    else if (!CI) chain_q <= chain_q - 1'b1;
  end

  // Reference model: mode 0 idle, 1 load, 2 run; run_cycles counts RUN cycles
  // since the last load, ticks fall where run_cycles is a multiple of div.
  int           m_mode = 0;
  int           m_run_cycles = 0;
  int           m_div_m1 = 0;
  logic [W-1:0] m_cnt = '0;
  logic [W-1:0] m_reload = '0;
  bit           m_auto = 0, m_ien = 0, m_irq = 0;

  bit           e_tick, e_expiry, e_ld, e_ci;
  logic [W-1:0] e_cntd;
  always_comb begin
    e_tick   = (m_mode == 2) && ((m_run_cycles % (m_div_m1 + 1)) == 0);
    e_expiry = e_tick && (m_cnt == 0);
    e_ld     = (m_mode == 1) || e_expiry;
    e_cntd   = '0;
    if (m_mode == 1)   e_cntd = m_reload;
    else if (e_expiry) e_cntd = m_auto ? m_reload : '0;
    // A decrement happens on a tick unless a STOP (without START) holds a nonzero count.
    e_ci = !(e_tick && (!STOP || (WR_CTRL && CTRL_D[0]) || m_cnt == 0));
  end

  always @(posedge clk) begin
    bit start;
    start = WR_CTRL && CTRL_D[0];
    if (RESET) m_cnt = '0;
    else if (e_ld) m_cnt = e_cntd;
    else if (!e_ci) m_cnt = m_cnt - 1'b1;
    if (RESET) begin
      m_mode = 0; m_run_cycles = 0; m_div_m1 = 0;
      m_reload = '0; m_auto = 0; m_ien = 0; m_irq = 0;
    end else begin
      if (IRQ_ACK) m_irq = 0;
      if (e_expiry && m_ien) m_irq = 1;
      if (m_mode == 1) m_run_cycles = 0;
      else if (m_mode == 2) m_run_cycles++;
      if (start) m_mode = 1;
      else if (m_mode == 1) m_mode = 2;
      else if (m_mode == 2) begin
        if (e_expiry) m_mode = (STOP || !m_auto) ? 0 : 2;
        else if (STOP) m_mode = 0;
      end
      if (WR_RELOAD) m_reload = RELOAD_D;
      if (WR_CTRL) begin
        m_auto = CTRL_D[1];
        m_ien  = CTRL_D[2];
`ifdef LSCNT_CTRL_PRESCALE_EN
        m_div_m1 = int'(PRESCALE_D);
`endif
      end
    end
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("m_ld",   32'(LD),    32'(e_ld));
      cmp("m_ldl",  32'(LDL),   32'(!e_ld));
      cmp("m_ci",   32'(CI),    32'(e_ci));
      cmp("m_cntd", 32'(CNT_D), 32'(e_cntd));
      cmp("m_irq",  32'(IRQ),   32'(m_irq));
      cmp("m_busy", 32'(BUSY),  32'(m_mode != 0));
      cmp("m_cntq", 32'(CNT_Q), 32'(m_cnt));
      cmp("no_wrap", 32'(CNT_Q == 16'hFFFF), 32'd0);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wr_reload(input logic [W-1:0] n);
    RELOAD_D = n; WR_RELOAD = 1'b1; step(); WR_RELOAD = 1'b0;
  endtask

  // Issues WR_CTRL in "cycle 0"; returns at the start of cycle 1.
  task automatic wr_ctrl(input logic [2:0] c, input logic [P-1:0] p);
    CTRL_D = c; PRESCALE_D = p; WR_CTRL = 1'b1; step(); WR_CTRL = 1'b0;
  endtask

  initial begin
    step(); step();
    RESET = 1'b0;
    chk_en = 1'b1;
    cmp("rst_ld", 32'(LD), 0);   cmp("rst_ldl", 32'(LDL), 1);
    cmp("rst_ci", 32'(CI), 1);   cmp("rst_cntd", 32'(CNT_D), 0);
    cmp("rst_irq", 32'(IRQ), 0); cmp("rst_busy", 32'(BUSY), 0);

    // N=3 one-shot with IRQ
    wr_reload(3); wr_ctrl(3'b101, 0);
    cmp("t1_c1_ld", 32'(LD), 1); cmp("t1_c1_cntd", 32'(CNT_D), 3); cmp("t1_c1_busy", 32'(BUSY), 1);
    step(); cmp("t1_c2", 32'(CNT_Q), 3);
    step(); cmp("t1_c3", 32'(CNT_Q), 2);
    step(); cmp("t1_c4", 32'(CNT_Q), 1);
    step(); cmp("t1_c5_q", 32'(CNT_Q), 0); cmp("t1_c5_ld", 32'(LD), 1); cmp("t1_c5_cntd", 32'(CNT_D), 0);
    step(); cmp("t1_c6_irq", 32'(IRQ), 1); cmp("t1_c6_busy", 32'(BUSY), 0); cmp("t1_c6_q", 32'(CNT_Q), 0);
    step(); cmp("t1_c7_q", 32'(CNT_Q), 0);
    IRQ_ACK = 1'b1; step(); IRQ_ACK = 1'b0;
    cmp("t1_ack", 32'(IRQ), 0);

    // N=2 auto-reload, ack held: IRQ pulses one cycle after each expiry
    wr_reload(2); IRQ_ACK = 1'b1; wr_ctrl(3'b111, 0);
    step(); step();
    step(); cmp("t2_c4_ld", 32'(LD), 1); cmp("t2_c4_cntd", 32'(CNT_D), 2);
    step(); cmp("t2_c5_irq", 32'(IRQ), 1);
    step(); cmp("t2_c6_irq", 32'(IRQ), 0);
    step(); cmp("t2_c7_ld", 32'(LD), 1);
    step(); cmp("t2_c8_irq", 32'(IRQ), 1);
    step(); step(); cmp("t2_c10_ld", 32'(LD), 1);
    STOP = 1'b1; step(); STOP = 1'b0;
    cmp("t2_stop_busy", 32'(BUSY), 0); cmp("t2_stop_irq", 32'(IRQ), 1);
    step(); IRQ_ACK = 1'b0;
    cmp("t2_irq_clr", 32'(IRQ), 0);

    // N=0 one-shot: expiry on first tick, no wrap
    wr_reload(0); wr_ctrl(3'b001, 0);
    cmp("t3_c1_ld", 32'(LD), 1);
    step(); cmp("t3_c2_ld", 32'(LD), 1); cmp("t3_c2_cntd", 32'(CNT_D), 0);
    step(); cmp("t3_c3_busy", 32'(BUSY), 0); cmp("t3_c3_q", 32'(CNT_Q), 0);

    // N=5, STOP with count 3
    wr_reload(5); wr_ctrl(3'b101, 0);
    step(); step();
    step(); cmp("t4_c4_q", 32'(CNT_Q), 3);
    STOP = 1'b1; #1; cmp("t4_stop_ci", 32'(CI), 1);
    step(); STOP = 1'b0;
    cmp("t4_c5_busy", 32'(BUSY), 0); cmp("t4_c5_q", 32'(CNT_Q), 3);
    step(); step(); cmp("t4_hold_q", 32'(CNT_Q), 3);

    // STOP in expiry with auto-reload: IRQ, reload, idle
    wr_reload(1); wr_ctrl(3'b111, 0);
    step(); step(); cmp("t4b_exp_ld", 32'(LD), 1);
    STOP = 1'b1; step(); STOP = 1'b0;
    cmp("t4b_irq", 32'(IRQ), 1); cmp("t4b_busy", 32'(BUSY), 0); cmp("t4b_q", 32'(CNT_Q), 1);

    // IRQ pending; expiry with ACK in the same cycle keeps IRQ
    wr_reload(0); wr_ctrl(3'b101, 0);
    step(); IRQ_ACK = 1'b1; step(); IRQ_ACK = 1'b0;
    cmp("t5_set_wins", 32'(IRQ), 1);

    // Restart while running
    wr_reload(4); wr_ctrl(3'b001, 0);
    step(); step(); cmp("t5r_q", 32'(CNT_Q), 3);
    wr_ctrl(3'b001, 0);
    cmp("t5r_ld", 32'(LD), 1); cmp("t5r_cntd", 32'(CNT_D), 4);
    step(); cmp("t5r_q4", 32'(CNT_Q), 4);

    // Reset mid-run (IRQ still pending)
    step();
    RESET = 1'b1; step(); RESET = 1'b0;
    cmp("t5x_ci", 32'(CI), 1); cmp("t5x_ld", 32'(LD), 0);
    cmp("t5x_irq", 32'(IRQ), 0); cmp("t5x_busy", 32'(BUSY), 0);

    // Prescale P=1, N=1
    wr_reload(1); wr_ctrl(3'b101, 1);
    step(); cmp("t6_c2_ci", 32'(CI), 0);
`ifdef LSCNT_CTRL_PRESCALE_EN
    step(); cmp("t6_c3_ci", 32'(CI), 1); cmp("t6_c3_ld", 32'(LD), 0);
    step(); cmp("t6_c4_ld", 32'(LD), 1);
    step(); cmp("t6_c5_irq", 32'(IRQ), 1);
`else
    step(); cmp("t6_c3_ld", 32'(LD), 1);
    step(); cmp("t6_c4_irq", 32'(IRQ), 1);
`endif
    step(); step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
